// File: rtl/bsr_chain_if.sv
// rtl/bsr_chain_if.sv - TAP data-register path and pin/core bundle for the boundary-scan chain
//
// Purpose: groups the serial scan path, the TAP DR-state strobes, the pin-mux
//          mode and the parallel pin/core buses of one boundary-scan register.
// Signals:
//   tdi        serial data into chain position 0
//   tdo        serial data out of chain position L-1
//   capture_dr load shift stage from pins/core
//   shift_dr   shift chain one position toward tdo
//   update_dr  copy shift stage into update stage
//   mode       0=functional 1=sample/preload 2=extest 3=intest
//   pin_in     package input pins          core_in   values driven into the core
//   core_out   values produced by the core pin_out   values driven to output pins
// Modports: master = TAP/pad side driving strobes, slave = the scan chain.

interface bsr_chain_if #(
  parameter int NUM_IN  = 3,
  parameter int NUM_OUT = 2
);
  logic               tdi;
  logic               tdo;
  logic               capture_dr;
  logic               shift_dr;
  logic               update_dr;
  logic [1:0]         mode;
  logic [NUM_IN-1:0]  pin_in;
  logic [NUM_IN-1:0]  core_in;
  logic [NUM_OUT-1:0] core_out;
  logic [NUM_OUT-1:0] pin_out;

  modport master (
    output tdi, capture_dr, shift_dr, update_dr, mode, pin_in, core_out,
    input  tdo, core_in, pin_out
  );

  modport slave (
    input  tdi, capture_dr, shift_dr, update_dr, mode, pin_in, core_out,
    output tdo, core_in, pin_out
  );
endinterface

// File: rtl/bsr_chain.sv
// rtl/bsr_chain.sv - parametrised boundary-scan register chain with capture/shift/update stages
//
// Purpose: NUM_IN input cells (chain positions 0..NUM_IN-1) followed by NUM_OUT
//          output cells (positions NUM_IN..L-1) forming one serial chain, with a
//          shift stage (sr), an update stage (ur) and the pin/core muxes.
// Ports:
//   tck   sole clock, rising edge
//   trst  synchronous active-high reset, overrides every strobe
//   bus   bsr_chain_if.slave: tdi/tdo, capture_dr/shift_dr/update_dr, mode,
//         pin_in/core_in, core_out/pin_out
// Configuration:
//   BSR_INTEST_EN  when defined, mode 3 drives core_in from ur[NUM_IN-1:0];
//                  when undefined, mode 3 is identical to mode 0.

module bsr_chain #(
  parameter int NUM_IN  = 3,
  parameter int NUM_OUT = 2
) (
  input logic       tck,
  input logic       trst,
  bsr_chain_if.slave bus
);

  localparam int L = NUM_IN + NUM_OUT;

  localparam logic [1:0] MODE_EXTEST = 2'd2;
`ifdef BSR_INTEST_EN
  localparam logic [1:0] MODE_INTEST = 2'd3;
`endif

  logic [L-1:0] sr;
  logic [L-1:0] ur;

  // Capture wins over shift; update always samples the pre-edge shift stage,
  // so it is independent of whatever capture/shift does on the same edge.
  always_ff @(posedge tck) begin
    if (trst) begin
      sr <= '0;
      ur <= '0;
    end else begin
      if (bus.capture_dr) begin
        sr <= {bus.core_out, bus.pin_in};
      end else if (bus.shift_dr) begin
        sr <= {sr[L-2:0], bus.tdi};
      end
      if (bus.update_dr) begin
        ur <= sr;
      end
    end
  end

  // sr is a register, so tdo has no combinational path from tdi.
  assign bus.tdo = sr[L-1];

  assign bus.pin_out = (bus.mode == MODE_EXTEST) ? ur[L-1:NUM_IN] : bus.core_out;

`ifdef BSR_INTEST_EN
  assign bus.core_in = (bus.mode == MODE_INTEST) ? ur[NUM_IN-1:0] : bus.pin_in;
`else
  // Input-cell update bits are still loaded but have no consumer without intest.
  logic unused_ur_in;
  assign unused_ur_in = &{1'b0, ur[NUM_IN-1:0]};
  assign bus.core_in  = bus.pin_in;
`endif

endmodule

// File: tb/tb_bsr_chain.sv
// tb/tb_bsr_chain.sv - self-checking bench for bsr_chain (NUM_IN=3, NUM_OUT=2)

module tb_bsr_chain;

  localparam int NUM_IN  = 3;
  localparam int NUM_OUT = 2;

`ifdef BSR_INTEST_EN
  localparam bit INTEST = 1'b1;
`else
  localparam bit INTEST = 1'b0;
`endif

  logic tck;
  logic trst;

  bsr_chain_if #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) bus ();

  bsr_chain #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) dut (
    .tck  (tck),
    .trst (trst),
    .bus  (bus)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  int n_cmp;
  int n_err;
  bit exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; tdo is sampled 1 time unit later and matched against the
  // oldest expected value queued when the stimulus for this edge was set up.
  task automatic tick_sb();
    bit e;
    @(posedge tck);
    #1;
    check("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("tdo", bus.tdo, e);
    end
  endtask

  task automatic do_capture(input bit exp_tdo);
    bus.capture_dr = 1'b1;
    exp_q.push_back(exp_tdo);
    tick_sb();
    bus.capture_dr = 1'b0;
  endtask

  task automatic do_shift(input bit b, input bit exp_tdo);
    bus.tdi      = b;
    bus.shift_dr = 1'b1;
    exp_q.push_back(exp_tdo);
    tick_sb();
    bus.shift_dr = 1'b0;
  endtask

  task automatic do_update(input bit exp_tdo);
    bus.update_dr = 1'b1;
    exp_q.push_back(exp_tdo);
    tick_sb();
    bus.update_dr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] bits;
    logic [1:0] co;
    n_cmp = 0;
    n_err = 0;
    trst = 1'b0;
    bus.tdi = 1'b0;
    bus.capture_dr = 1'b0;
    bus.shift_dr = 1'b0;
    bus.update_dr = 1'b0;
    bus.mode = 2'd2;
    bus.pin_in = 3'b011;
    bus.core_out = 2'b11;

    // Reset with random strobes
    @(negedge tck);
    trst = 1'b1;
    bus.capture_dr = 1'($urandom_range(0, 1));
    bus.shift_dr   = 1'($urandom_range(0, 1));
    bus.update_dr  = 1'($urandom_range(0, 1));
    bus.tdi        = 1'($urandom_range(0, 1));
    @(posedge tck);
    #1;
    trst = 1'b0;
    bus.capture_dr = 1'b0;
    bus.shift_dr = 1'b0;
    bus.update_dr = 1'b0;
    #1;
    check("rst_tdo", bus.tdo, 0);
    check("rst_pin_out_extest", bus.pin_out, 2'b00);
    check("rst_core_in_m2", bus.core_in, 3'b011);
    bus.mode = 2'd3;
    bus.pin_in = 3'b110;
    #1;
    check("rst_core_in_m3", bus.core_in, INTEST ? 3'b000 : 3'b110);

    // Capture and shift out in sample/preload mode
    bus.mode = 2'd1;
    bus.pin_in = 3'b101;
    bus.core_out = 2'b10;
    do_capture(1'b1);
    bits = 5'b01010;  // expected tdo after shifts 1..5, first in bit 4
    for (int i = 0; i < 5; i++) begin
      co = 2'($urandom_range(0, 3));
      bus.core_out = co;
      do_shift(1'b0, bits[4-i]);
      check("m1_pin_out_track", bus.pin_out, co);
    end

    // Preload 1,1,0,0,0 -> ur[4]=ur[3]=1, then extest
    bits = 5'b11000;
    for (int i = 0; i < 5; i++) begin
      do_shift(bits[4-i], (i == 4) ? 1'b1 : 1'b0);
    end
    bus.core_out = 2'b00;
    do_update(1'b1);
    check("m1_pin_out_after_upd", bus.pin_out, 2'b00);
    bus.mode = 2'd2;
    #1;
    check("extest_pin_out_a", bus.pin_out, 2'b11);
    bus.core_out = 2'b01;
    #1;
    check("extest_pin_out_b", bus.pin_out, 2'b11);

    // Preload ur = 5'b00111, intest
    bus.mode = 2'd1;
    bits = 5'b00111;
    for (int i = 0; i < 5; i++) begin
      do_shift(bits[4-i], (i == 0) ? 1'b1 : 1'b0);
    end
    do_update(1'b0);
    bus.mode = 2'd3;
    bus.pin_in = 3'b000;
    #1;
    check("intest_core_in", bus.core_in, INTEST ? 3'b111 : 3'b000);
    bus.mode = 2'd2;
    #1;
    check("extest_after_intest", bus.pin_out, 2'b00);

    // Simultaneous strobes: sr pre-edge = 01100
    bus.mode = 2'd1;
    bus.pin_in = 3'b100;
    bus.core_out = 2'b01;
    do_capture(1'b0);
    bus.pin_in = 3'b010;
    bus.core_out = 2'b11;
    bus.tdi = 1'b0;
    bus.capture_dr = 1'b1;
    bus.shift_dr = 1'b1;
    bus.update_dr = 1'b1;
    exp_q.push_back(1'b1);
    tick_sb();
    bus.capture_dr = 1'b0;
    bus.shift_dr = 1'b0;
    bus.update_dr = 1'b0;
    bus.mode = 2'd2;
    #1;
    check("simul_ur_out", bus.pin_out, 2'b01);
    bus.mode = 2'd3;
    bus.pin_in = 3'b000;
    #1;
    check("simul_ur_in", bus.core_in, INTEST ? 3'b100 : 3'b000);
    bits = 5'b10100;  // sr = 11010 read out: sr[3..0] then tdi 0
    for (int i = 0; i < 5; i++) begin
      do_shift(1'b0, bits[4-i]);
    end

    // Reset mid-scan in extest
    bus.mode = 2'd2;
    #1;
    check("pre_rst_pin_out", bus.pin_out, 2'b01);
    do_shift(1'b1, 1'b0);
    do_shift(1'b1, 1'b0);
    trst = 1'b1;
    bus.shift_dr = 1'b1;
    exp_q.push_back(1'b0);
    tick_sb();
    trst = 1'b0;
    bus.shift_dr = 1'b0;
    check("rst_mid_pin_out", bus.pin_out, 2'b00);
    bits = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      do_shift(bits[4-i], (i == 4) ? 1'b1 : 1'b0);
    end
    do_update(1'b1);
    check("restart_pin_out", bus.pin_out, 2'b10);

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
